// File: rtl/csi2tx_dphy_esc_pkg.sv
// Shared definitions for the D-PHY low-power escape receiver: LP line-state
// encodings ({dp,dn}), FSM state enum and escape entry command codes.
`timescale 1ns/1ps
package csi2tx_dphy_esc_pkg;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

    typedef enum logic [3:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS,
        ST_ESC_RQST,
        ST_ESC_BRIDGE,
        ST_ESC_ACK,
        ST_CMD,
        ST_LPDT,
        ST_ULPS,
        ST_ULPS_EXIT,
        ST_WAIT_STOP
    } esc_state_t;

    // Command codes as they appear after MSB-first shifting (first bit in bit 7).
    localparam logic [7:0] CMD_LPDT       = 8'b1110_0001;
    localparam logic [7:0] CMD_ULPS       = 8'b0001_1110;
    localparam logic [7:0] CMD_TRIG_RESET = 8'b0110_0010;
    localparam logic [7:0] CMD_TRIG_UNK3  = 8'b0101_1101;
    localparam logic [7:0] CMD_TRIG_UNK4  = 8'b0010_0001;
    localparam logic [7:0] CMD_TRIG_UNK5  = 8'b1010_0000;

endpackage

// File: rtl/csi2tx_dphy_lp_filter.sv
// Two-flop synchronizer plus stability filter for one LP line pair; the
// filtered state only moves after FILT_CYCLES identical synchronized samples.
`timescale 1ns/1ps
module csi2tx_dphy_lp_filter
    import csi2tx_dphy_esc_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp,
    input  logic       dn,
    output logic [1:0] ls
);

    localparam logic [2:0] FILT_LIM = 3'(FILT_CYCLES);

    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] cand_reg;
    logic [1:0] ls_reg;
    logic [2:0] cnt_reg;

    // cand_reg tracks the run of samples that differ from the filtered state;
    // any sample matching the current state restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= LP_11;
            sync2_reg <= LP_11;
            cand_reg  <= LP_11;
            ls_reg    <= LP_11;
            cnt_reg   <= 3'd0;
        end else begin
            sync1_reg <= {dp, dn};
            sync2_reg <= sync1_reg;
            if (sync2_reg == ls_reg) begin
                cnt_reg <= 3'd0;
            end else if (sync2_reg != cand_reg) begin
                cand_reg <= sync2_reg;
                cnt_reg  <= 3'd1;
                if (FILT_LIM <= 3'd1) begin
                    ls_reg  <= sync2_reg;
                    cnt_reg <= 3'd0;
                end
            end else if (cnt_reg + 3'd1 >= FILT_LIM) begin
                ls_reg  <= sync2_reg;
                cnt_reg <= 3'd0;
            end else begin
                cnt_reg <= cnt_reg + 3'd1;
            end
        end
    end

    assign ls = ls_reg;

endmodule

// File: rtl/csi2tx_dphy_esc_rx.sv
// Per-lane LP line-state decoder and escape-mode receiver (LPDT, ULPS, triggers).
// Trigger decoding is enabled by defining CSI2TX_DPHY_ESC_TRIGGER_EN.
`timescale 1ns/1ps
module csi2tx_dphy_esc_rx
    import csi2tx_dphy_esc_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 2
) (
    input  logic       rxclkesc,
    input  logic       rcvclkesc_rst_n,
    input  logic       lp_rx_dp,
    input  logic       lp_rx_dn,
    output logic       rxlpdtesc,
    output logic [7:0] rxdataesc,
    output logic       rxvalidesc,
    output logic       rxulpsesc,
    output logic       ulpsactivenot,
    output logic [3:0] rxtriggeresc,
    output logic       hs_rqst,
    output logic       stopstate,
    output logic       erresc,
    output logic       errsyncesc,
    output logic       errcontrol
);

    logic [1:0] ls;
    logic [1:0] ls_prev_reg;
    esc_state_t state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] data_reg, data_next;
    logic       valid_reg, valid_next;
    logic       lpdt_reg, lpdt_next;
    logic       ulps_reg, ulps_next;
    logic       hs_reg, hs_next;
    logic       stop_reg, stop_next;
    logic       erresc_reg, erresc_next;
    logic       errsync_reg, errsync_next;
    logic       errctl_reg, errctl_next;
    logic       ls_chg;
    logic       bit_val;
    logic [7:0] cmd_word;
    logic [7:0] byte_word;
`ifdef CSI2TX_DPHY_ESC_TRIGGER_EN
    logic [3:0] trig_reg, trig_next;
`endif

    csi2tx_dphy_lp_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filter (
        .clk   (rxclkesc),
        .rst_n (rcvclkesc_rst_n),
        .dp    (lp_rx_dp),
        .dn    (lp_rx_dn),
        .ls    (ls)
    );

    // A bit is taken on mark -> LP-00, so the previous state says which mark it was.
    assign ls_chg    = (ls != ls_prev_reg);
    assign bit_val   = (ls_prev_reg == LP_10);
    assign cmd_word  = {shift_reg[6:0], bit_val};
    assign byte_word = {bit_val, shift_reg[7:1]};

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        erresc_next  = 1'b0;
        errsync_next = 1'b0;
        errctl_next  = 1'b0;
`ifdef CSI2TX_DPHY_ESC_TRIGGER_EN
        trig_next    = 4'b0000;
`endif
        case (state_reg)
            ST_STOP: begin
                if (ls_chg) begin
                    if (ls == LP_01) begin
                        state_next = ST_HS_RQST;
                    end else if (ls == LP_10) begin
                        state_next = ST_ESC_RQST;
                    end else if (ls == LP_00) begin
                        errctl_next = 1'b1;
                        state_next  = ST_WAIT_STOP;
                    end
                end
            end
            ST_HS_RQST, ST_ESC_RQST, ST_ESC_BRIDGE, ST_ESC_ACK: begin
                if (ls_chg) begin
                    if (ls == LP_11) begin
                        state_next = ST_STOP;
                    end else if (state_reg == ST_HS_RQST && ls == LP_00) begin
                        state_next = ST_HS;
                    end else if (state_reg == ST_ESC_RQST && ls == LP_00) begin
                        state_next = ST_ESC_BRIDGE;
                    end else if (state_reg == ST_ESC_BRIDGE && ls == LP_01) begin
                        state_next = ST_ESC_ACK;
                    end else if (state_reg == ST_ESC_ACK && ls == LP_00) begin
                        state_next   = ST_CMD;
                        shift_next   = 8'h00;
                        bit_cnt_next = 3'd0;
                    end else begin
                        errctl_next = 1'b1;
                        state_next  = ST_WAIT_STOP;
                    end
                end
            end
            ST_HS: begin
                if (ls_chg && ls == LP_11) begin
                    state_next = ST_STOP;
                end
            end
            ST_CMD, ST_LPDT: begin
                if (ls_chg) begin
                    if (ls == LP_11) begin
                        state_next = ST_STOP;
                        if (state_reg == ST_LPDT && bit_cnt_reg != 3'd0) begin
                            errsync_next = 1'b1;
                        end
                    end else if (ls == LP_00) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (state_reg == ST_LPDT) begin
                            shift_next = byte_word;
                            if (bit_cnt_reg == 3'd7) begin
                                data_next  = byte_word;
                                valid_next = 1'b1;
                            end
                        end else begin
                            shift_next = cmd_word;
                            if (bit_cnt_reg == 3'd7) begin
                                case (cmd_word)
                                    CMD_LPDT: state_next = ST_LPDT;
                                    CMD_ULPS: state_next = ST_ULPS;
`ifdef CSI2TX_DPHY_ESC_TRIGGER_EN
                                    CMD_TRIG_RESET: begin
                                        trig_next  = 4'b0001;
                                        state_next = ST_WAIT_STOP;
                                    end
                                    CMD_TRIG_UNK3: begin
                                        trig_next  = 4'b0010;
                                        state_next = ST_WAIT_STOP;
                                    end
                                    CMD_TRIG_UNK4: begin
                                        trig_next  = 4'b0100;
                                        state_next = ST_WAIT_STOP;
                                    end
                                    CMD_TRIG_UNK5: begin
                                        trig_next  = 4'b1000;
                                        state_next = ST_WAIT_STOP;
                                    end
`endif
                                    default: begin
                                        erresc_next = 1'b1;
                                        state_next  = ST_WAIT_STOP;
                                    end
                                endcase
                            end
                        end
                    end else if (ls_prev_reg != LP_00) begin
                        errctl_next = 1'b1;
                        state_next  = ST_WAIT_STOP;
                    end
                end
            end
            ST_ULPS: begin
                if (ls_chg) begin
                    if (ls == LP_11) begin
                        state_next = ST_STOP;
                    end else if (ls == LP_10) begin
                        state_next = ST_ULPS_EXIT;
                    end else begin
                        errctl_next = 1'b1;
                        state_next  = ST_WAIT_STOP;
                    end
                end
            end
            ST_ULPS_EXIT: begin
                if (ls_chg) begin
                    if (ls == LP_11) begin
                        state_next = ST_STOP;
                    end else begin
                        errctl_next = 1'b1;
                        state_next  = ST_WAIT_STOP;
                    end
                end
            end
            ST_WAIT_STOP: begin
                if (ls == LP_11) begin
                    state_next = ST_STOP;
                end
            end
            default: state_next = ST_STOP;
        endcase

        lpdt_next = (state_next == ST_LPDT);
        ulps_next = (state_next == ST_ULPS);
        stop_next = (state_next == ST_STOP) && (ls == LP_11);
        // HS request is held from its LP-01 until LP-11 is seen, whatever happens between.
        if (state_reg == ST_STOP && state_next == ST_HS_RQST) begin
            hs_next = 1'b1;
        end else if (ls == LP_11) begin
            hs_next = 1'b0;
        end else begin
            hs_next = hs_reg;
        end
    end

    always_ff @(posedge rxclkesc or negedge rcvclkesc_rst_n) begin
        if (!rcvclkesc_rst_n) begin
            state_reg   <= ST_STOP;
            ls_prev_reg <= LP_11;
            shift_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
            data_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            lpdt_reg    <= 1'b0;
            ulps_reg    <= 1'b0;
            hs_reg      <= 1'b0;
            stop_reg    <= 1'b0;
            erresc_reg  <= 1'b0;
            errsync_reg <= 1'b0;
            errctl_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ls_prev_reg <= ls;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            lpdt_reg    <= lpdt_next;
            ulps_reg    <= ulps_next;
            hs_reg      <= hs_next;
            stop_reg    <= stop_next;
            erresc_reg  <= erresc_next;
            errsync_reg <= errsync_next;
            errctl_reg  <= errctl_next;
        end
    end

`ifdef CSI2TX_DPHY_ESC_TRIGGER_EN
    always_ff @(posedge rxclkesc or negedge rcvclkesc_rst_n) begin
        if (!rcvclkesc_rst_n) begin
            trig_reg <= 4'b0000;
        end else begin
            trig_reg <= trig_next;
        end
    end
    assign rxtriggeresc = trig_reg;
`else
    assign rxtriggeresc = 4'b0000;
`endif

    assign rxlpdtesc     = lpdt_reg;
    assign rxdataesc     = data_reg;
    assign rxvalidesc    = valid_reg;
    assign rxulpsesc     = ulps_reg;
    assign ulpsactivenot = ~ulps_reg;
    assign hs_rqst       = hs_reg;
    assign stopstate     = stop_reg;
    assign erresc        = erresc_reg;
    assign errsyncesc    = errsync_reg;
    assign errcontrol    = errctl_reg;

endmodule

// File: tb/tb_csi2tx_dphy_esc_rx.sv
// Randomized scoreboard bench for csi2tx_dphy_esc_rx: stimulus is built from
// line-state transactions, expected strobes are queued and a monitor pops them.
`timescale 1ns/1ps
module tb_csi2tx_dphy_esc_rx;

    localparam int EV_BYTE    = 0;
    localparam int EV_ERRESC  = 1;
    localparam int EV_ERRSYNC = 2;
    localparam int EV_ERRCTL  = 3;
    localparam int EV_TRIG    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dp = 1'b1;
    logic       dn = 1'b1;
    logic       rxlpdtesc;
    logic [7:0] rxdataesc;
    logic       rxvalidesc;
    logic       rxulpsesc;
    logic       ulpsactivenot;
    logic [3:0] rxtriggeresc;
    logic       hs_rqst;
    logic       stopstate;
    logic       erresc;
    logic       errsyncesc;
    logic       errcontrol;

    always #5 clk = ~clk;

    csi2tx_dphy_esc_rx #(.FILT_CYCLES(2)) dut (
        .rxclkesc        (clk),
        .rcvclkesc_rst_n (rst_n),
        .lp_rx_dp        (dp),
        .lp_rx_dn        (dn),
        .rxlpdtesc       (rxlpdtesc),
        .rxdataesc       (rxdataesc),
        .rxvalidesc      (rxvalidesc),
        .rxulpsesc       (rxulpsesc),
        .ulpsactivenot   (ulpsactivenot),
        .rxtriggeresc    (rxtriggeresc),
        .hs_rqst         (hs_rqst),
        .stopstate       (stopstate),
        .erresc          (erresc),
        .errsyncesc      (errsyncesc),
        .errcontrol      (errcontrol)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int total = 0;
    int bad = 0;
    logic [7:0] trig_codes [4] = '{8'h62, 8'h5D, 8'h21, 8'hA0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic expect_ev(input int k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [7:0] d);
        ev_t e;
        total++;
        $display("event kind=%0d data=%02h at %0t", k, d, $time);
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h, want none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                bad++;
                $display("FAIL event_order: got kind=%0d data=%02h, want kind=%0d data=%02h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rxvalidesc)           observe(EV_BYTE, rxdataesc);
        if (erresc)               observe(EV_ERRESC, 8'h00);
        if (errsyncesc)           observe(EV_ERRSYNC, 8'h00);
        if (errcontrol)           observe(EV_ERRCTL, 8'h00);
        if (rxtriggeresc != 4'b0) observe(EV_TRIG, {4'b0000, rxtriggeresc});
    end

    // Hold a line state long enough to clear sync + filter + output register.
    task automatic line(input logic [1:0] v);
        {dp, dn} = v;
        repeat ($urandom_range(6, 9)) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        line(b ? 2'b10 : 2'b01);
        line(2'b00);
    endtask

    task automatic entry();
        line(2'b10);
        line(2'b00);
        line(2'b01);
        line(2'b00);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    // Expected reaction to an 8-bit entry command that is neither LPDT nor ULPS.
    task automatic expect_for_cmd(input logic [7:0] c);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) if (c == trig_codes[i]) idx = i;
`ifdef CSI2TX_DPHY_ESC_TRIGGER_EN
        if (idx >= 0) expect_ev(EV_TRIG, 8'(1 << idx));
        else          expect_ev(EV_ERRESC, 8'h00);
`else
        expect_ev(EV_ERRESC, 8'h00);
`endif
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_stop(input string name);
        int n;
        n = 0;
        while (!stopstate && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, stopstate, 1);
    endtask

    task automatic lpdt_burst(input int nbytes, input string name);
        logic [7:0] d;
        entry();
        send_cmd(8'hE1);
        chk({name, "_lpdt_on"}, rxlpdtesc, 1);
        for (int i = 0; i < nbytes; i++) begin
            d = 8'($urandom_range(0, 255));
            expect_ev(EV_BYTE, d);
            send_byte(d);
            chk({name, "_lpdt_held"}, rxlpdtesc, 1);
        end
        line(2'b10);
        line(2'b11);
        chk({name, "_lpdt_off"}, rxlpdtesc, 0);
        chk({name, "_stop"}, stopstate, 1);
        drain({name, "_drain"});
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_rxdataesc"}, rxdataesc, 8'h00);
        chk({name, "_rxvalidesc"}, rxvalidesc, 0);
        chk({name, "_rxlpdtesc"}, rxlpdtesc, 0);
        chk({name, "_rxulpsesc"}, rxulpsesc, 0);
        chk({name, "_ulpsactivenot"}, ulpsactivenot, 1);
        chk({name, "_rxtriggeresc"}, rxtriggeresc, 0);
        chk({name, "_hs_rqst"}, hs_rqst, 0);
        chk({name, "_stopstate"}, stopstate, 0);
        chk({name, "_errs"}, {erresc, errsyncesc, errcontrol}, 0);
    endtask

    initial begin
        logic [7:0] c;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        wait_stop("stop_after_reset");

        // LPDT with the two fixed bytes, then random bursts.
        entry();
        send_cmd(8'hE1);
        chk("lpdt_on", rxlpdtesc, 1);
        expect_ev(EV_BYTE, 8'hA5);
        send_byte(8'hA5);
        chk("lpdt_held_a5", rxlpdtesc, 1);
        chk("data_hold_a5", rxdataesc, 8'hA5);
        expect_ev(EV_BYTE, 8'h3C);
        send_byte(8'h3C);
        chk("data_hold_3c", rxdataesc, 8'h3C);
        line(2'b11);
        chk("lpdt_off", rxlpdtesc, 0);
        drain("lpdt_fixed");
        for (int r = 0; r < 3; r++) lpdt_burst($urandom_range(1, 3), "lpdt_rand");

        // Partial byte at exit.
        entry();
        send_cmd(8'hE1);
        c = 8'($urandom_range(0, 255));
        expect_ev(EV_BYTE, c);
        send_byte(c);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        expect_ev(EV_ERRSYNC, 8'h00);
        line(2'b11);
        chk("partial_stop", stopstate, 1);
        drain("partial");

        // ULPS entry and exit.
        entry();
        send_cmd(8'h1E);
        chk("ulps_on", rxulpsesc, 1);
        chk("ulps_active_low", ulpsactivenot, 0);
        chk("ulps_not_lpdt", rxlpdtesc, 0);
        line(2'b10);
        chk("ulps_exit_off", rxulpsesc, 0);
        chk("ulps_exit_active", ulpsactivenot, 1);
        chk("ulps_exit_nostop", stopstate, 0);
        line(2'b11);
        chk("ulps_stop", stopstate, 1);
        drain("ulps");

        // Trigger codes (or escape errors when triggers are not built in).
        for (int i = 0; i < 4; i++) begin
            entry();
            expect_for_cmd(trig_codes[i]);
            send_cmd(trig_codes[i]);
            line(2'b11);
            drain("trigger");
        end

        // Unknown commands: all-ones and random non-LPDT/ULPS codes.
        entry();
        expect_for_cmd(8'hFF);
        send_cmd(8'hFF);
        line(2'b11);
        drain("cmd_ff");
        for (int r = 0; r < 3; r++) begin
            do c = 8'($urandom_range(0, 255)); while (c == 8'hE1 || c == 8'h1E);
            entry();
            expect_for_cmd(c);
            send_cmd(c);
            line(2'b11);
            drain("cmd_rand");
        end

        // Illegal LP sequences.
        expect_ev(EV_ERRCTL, 8'h00);
        line(2'b00);
        chk("errctl_nostop", stopstate, 0);
        line(2'b11);
        chk("errctl_stop", stopstate, 1);
        drain("stop_to_00");
        entry();
        expect_ev(EV_ERRCTL, 8'h00);
        line(2'b10);
        line(2'b01);
        line(2'b11);
        drain("mark_to_mark");

        // Single-sample LP-00 glitches must not be seen.
        for (int r = 0; r < 4; r++) begin
            {dp, dn} = 2'b00;
            @(negedge clk);
            {dp, dn} = 2'b11;
            repeat (8) @(negedge clk);
            chk("glitch_stop", stopstate, 1);
        end
        drain("glitch");

        // HS request path.
        line(2'b01);
        chk("hs_rqst_on", hs_rqst, 1);
        chk("hs_rqst_nostop", stopstate, 0);
        line(2'b00);
        chk("hs_rqst_held", hs_rqst, 1);
        line(2'b11);
        chk("hs_rqst_off", hs_rqst, 0);
        chk("hs_stop", stopstate, 1);
        drain("hs");

        // Reset in the middle of an LPDT byte.
        entry();
        send_cmd(8'hE1);
        c = 8'($urandom_range(1, 255));
        expect_ev(EV_BYTE, c);
        send_byte(c);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        {dp, dn} = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_stop("stop_after_midreset");
        drain("midreset");
        lpdt_burst(2, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csi2tx_dphy_esc_rx.md
# csi2tx_dphy_esc_rx

Per-data-lane low-power line-state decoder and escape-mode receiver for the D-PHY model; sits directly downstream of the clock/reset unit and consumes one lane's `lp_rx_dp`/`lp_rx_dn` pair, its escape clock, and its escape-domain reset. It does the following:
- Oversamples and filters the LP lines.
- Tracks the LP state sequence (stop, HS request, escape entry).
- Decodes spaced-one-hot escape commands.
- Delivers LPDT bytes, ULPS status and trigger events with PPI-style strobes and error flags.

## Interface
- `FILT_CYCLES`, default 2: consecutive identical synchronized samples required before the filtered line state changes (1..7).
- `rxclkesc` input 1: free-running escape clock from the clock/reset unit. Single clock; all logic runs on its rising edge.
- `rcvclkesc_rst_n` input 1: reset, asynchronous, active-low.
- `lp_rx_dp`, `lp_rx_dn` input 1 each: raw LP receiver outputs. They are asynchronous to `rxclkesc`.
- `rxlpdtesc` output 1: high while in LPDT mode.
- `rxdataesc` output 8: received LPDT byte, first-received bit at bit 0. Held until the next byte.
- `rxvalidesc` output 1: one-cycle strobe, `rxdataesc` valid.
- `rxulpsesc` output 1: high while in ULPS.
- `ulpsactivenot` output 1: low while in ULPS, released on exit.
- `rxtriggeresc` output 4: one-cycle trigger strobe (bit0 reset-trigger, bit1..3 unknown-3..5).
- `hs_rqst` output 1: high from LP-01-after-LP-11 until the next LP-11.
- `stopstate` output 1: high while the filtered state is LP-11 and the FSM is in STOP.
- `erresc` output 1: one-cycle strobe for an unrecognized entry command.
- `errsyncesc` output 1: one-cycle strobe when LPDT exits with a partial byte.
- `errcontrol` output 1: one-cycle strobe for an illegal LP sequence.

## Operation
- Front end: two-flop synchronizer on `{dp,dn}`, then the filter. The filtered state `ls` is one of LP-11, LP-10, LP-01, LP-00.
- FSM states: STOP, HS_RQST, HS, ESC_RQST, ESC_BRIDGE, ESC_ACK, CMD, LPDT, ULPS, ULPS_EXIT, WAIT_STOP.
- Entry and HS path transitions:
  - STOP: LP-01 -> HS_RQST; LP-10 -> ESC_RQST; LP-00 -> errcontrol, WAIT_STOP.
  - HS_RQST: LP-00 -> HS.
  - HS: LP-11 -> STOP.
  - ESC_RQST: LP-00 -> ESC_BRIDGE.
  - ESC_BRIDGE: LP-01 -> ESC_ACK.
  - ESC_ACK: LP-00 -> CMD.
  - Any other `ls` change in HS_RQST, ESC_RQST, ESC_BRIDGE or ESC_ACK: LP-11 -> STOP silently; otherwise errcontrol and WAIT_STOP.
- Bit decoding in CMD and LPDT:
  - A Mark-1 (LP-10) followed by LP-00 is bit 1.
  - A Mark-0 (LP-01) followed by LP-00 is bit 0.
  - A bit is accepted on the transition mark -> LP-00.
  - A mark directly followed by the opposite mark is errcontrol, then WAIT_STOP.
- Command decoding (CMD shifts the first bit into bit 7; the code is compared after 8 bits):
  - 11100001 -> LPDT.
  - 00011110 -> ULPS.
  - 01100010 / 01011101 / 00100001 / 10100000 -> `rxtriggeresc` bit 0/1/2/3, then WAIT_STOP.
  - Anything else -> erresc, then WAIT_STOP.
- LPDT: bits are shifted in LSB-first. On the 8th accepted bit the byte is loaded into `rxdataesc` and `rxvalidesc` is pulsed. The bit counter wraps 7 -> 0.
- Exit from any escape state: LP-11 -> STOP. If in LPDT with bit counter ≠ 0, errsyncesc pulses at the same time.
- ULPS:
  - LP-10 -> ULPS_EXIT. `rxulpsesc` drops and `ulpsactivenot` rises on entering ULPS_EXIT.
  - ULPS_EXIT: LP-11 -> STOP.
- WAIT_STOP: waits for LP-11, then -> STOP.
- Reset mid-operation: outputs return to their reset values immediately and the FSM goes to STOP. The partial byte is discarded with no error strobe.

## Timing
- Reset values:
  - `ulpsactivenot` = 1.
  - `rxdataesc` = 0.
  - All other outputs = 0, including `stopstate`. `stopstate` first rises when the filtered LP-11 is seen.
  - Synchronizer flops reset to 2'b11; the filter resets to LP-11.
- Line-to-`ls` latency: 2 sync cycles + `FILT_CYCLES` cycles.
- All status outputs are registered and change one cycle after `ls` changes.
- All strobes are exactly one cycle wide.
- The byte-complete and LP-11 exit conditions cannot occur in the same cycle, because `ls` changes at most once per cycle.
- A glitch shorter than `FILT_CYCLES` samples is invisible.

## Configuration
- `CSI2TX_DPHY_ESC_TRIGGER_EN`:
  - Defined: the four trigger codes are decoded as described.
  - Undefined: trigger codes fall into the erresc path and `rxtriggeresc` is tied to 0.

## Structure
- Package `csi2tx_dphy_esc_pkg` holds:
  - LP state encodings.
  - The FSM state enum.
  - The command constants (LPDT, ULPS, the four triggers).
- Sub-module `csi2tx_dphy_lp_filter` contains the synchronizer and the `FILT_CYCLES` stability filter, and outputs `ls[1:0]`.

## Test plan
- Entry 11-10-00-01-00, command 11100001, data bytes 0xA5 then 0x3C, LP-11 -> two `rxvalidesc` pulses with `rxdataesc` 0xA5 then 0x3C; `rxlpdtesc` high throughout; no errors.
- LPDT with 5 bits of a byte, then LP-11 -> errsyncesc one pulse, `stopstate` returns to 1.
- Command 00011110, then LP-10 held, then LP-11:
  - `rxulpsesc` = 1 and `ulpsactivenot` = 0 during ULPS.
  - Both are released at LP-10.
  - `stopstate` rises at LP-11.
- Command 01100010: with the macro defined -> `rxtriggeresc` = 4'b0001 for one cycle; without it -> erresc pulse.
- Error cases:
  - LP-11 -> LP-00 -> errcontrol.
  - Command 11111111 -> erresc.
  - LP-10 -> LP-01 in CMD -> errcontrol.
  - A 1-cycle LP-00 glitch with `FILT_CYCLES` = 2 -> no state change.
- `rcvclkesc_rst_n` asserted mid-LPDT byte -> all outputs at reset values immediately; the next entry sequence decodes cleanly.
